// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank controller: register word addresses and
// the TRIS reset pattern.
package gpio_pkg;

  localparam logic [2:0] GPIO_ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] GPIO_ADDR_TRIS     = 3'd2;
  localparam logic [2:0] GPIO_ADDR_RISE_EN  = 3'd3;
  localparam logic [2:0] GPIO_ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] GPIO_ADDR_EDGE_CAP = 3'd5;
  localparam logic [2:0] GPIO_ADDR_OUT_SET  = 3'd6;
  localparam logic [2:0] GPIO_ADDR_OUT_CLR  = 3'd7;

  // Every pin comes out of reset as an input (high-Z).
  localparam logic [31:0] GPIO_TRIS_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpio_sync_filter.sv
// One pin's input conditioning: SYNC_STAGES-deep synchroniser followed, when
// GPIO_DEBOUNCE_EN is defined, by a tick-driven stability counter.
module gpio_sync_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CNT = 3
`endif
) (
  input  logic clk,
  input  logic reset_n,
`ifdef GPIO_DEBOUNCE_EN
  input  logic i_tick,
`endif
  input  logic i_pad,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbour; a blocking = here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Any tick agreeing with the accepted level restarts the stability run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_tick) begin
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
`else
  assign o_level = w_synced;
`endif

endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: Avalon-MM register file, per-pin tri-state, edge capture
// and level IRQ. Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_oe
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_DIV < 1 || DEBOUNCE_CNT < 1)
  begin : g_bad_params
    $error("gpio_bank_ctrl: illegal parameter value");
  end

  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_tris;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_in_d;
  logic [31:0]      r_readdata;
  logic             r_irq;
  logic [WW-1:0]    r_warm;

  logic [WIDTH-1:0] w_in_q;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_edge_clr;
  logic [31:0]      w_rdata;
  logic             w_warm_done;

`ifdef GPIO_DEBOUNCE_EN
  localparam int PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      , .DEBOUNCE_CNT(DEBOUNCE_CNT)
`endif
    ) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef GPIO_DEBOUNCE_EN
      .i_tick  (w_tick),
`endif
      .i_pad   (pad_i[i]),
      .o_level (w_in_q[i])
    );
  end

  assign w_wd        = writedata[WIDTH-1:0];
  assign w_warm_done = (r_warm == WW'(WARM));

  // Capture is held off until the synchroniser and in_d hold real pad history.
  assign w_edge_set = w_warm_done
                    ? ((w_in_q & ~r_in_d & r_rise_en) | (~w_in_q & r_in_d & r_fall_en))
                    : '0;
  assign w_edge_clr = (write && address == GPIO_ADDR_EDGE_CAP) ? w_wd : '0;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    case (address)
      GPIO_ADDR_DATA_IN:  w_rdata = 32'(w_in_q);
      GPIO_ADDR_DATA_OUT: w_rdata = 32'(r_data_out);
      GPIO_ADDR_TRIS:     w_rdata = 32'(r_tris);
      GPIO_ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
      GPIO_ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
      GPIO_ADDR_EDGE_CAP: w_rdata = 32'(r_edge_cap);
      default:            w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_tris     <= GPIO_TRIS_RESET[WIDTH-1:0];
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_edge_cap <= '0;
      r_in_d     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      r_warm     <= '0;
    end else begin
      if (write) begin
        case (address)
          GPIO_ADDR_DATA_OUT: r_data_out <= w_wd;
          GPIO_ADDR_TRIS:     r_tris     <= w_wd;
          GPIO_ADDR_RISE_EN:  r_rise_en  <= w_wd;
          GPIO_ADDR_FALL_EN:  r_fall_en  <= w_wd;
          GPIO_ADDR_OUT_SET:  r_data_out <= r_data_out | w_wd;
          GPIO_ADDR_OUT_CLR:  r_data_out <= r_data_out & ~w_wd;
          default: ;
        endcase
      end
      // A new edge beats a W1C of the same bit in the same cycle.
      r_edge_cap <= (r_edge_cap & ~w_edge_clr) | w_edge_set;
      r_in_d     <= w_in_q;
      r_irq      <= |r_edge_cap;
      if (!w_warm_done) r_warm <= r_warm + 1'b1;
      // Read mux sees pre-write state, so a simultaneous write is not visible yet.
      if (read) r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;
  assign pad_o    = r_data_out;
  assign pad_oe   = ~r_tris;

endmodule
